// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit HH:MM display: walks one shared
// BCD decoder across the digits with a dead-time blank before each lit phase.
module disp_scan_ctrl #(
  parameter int PRESC       = 250,
  parameter int BLANK_TICKS = 1,
  parameter int DRIVE_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic       lzb_en,
  input  logic       colon_in,
  output logic [3:0] dec_val,
  output logic       dec_tens,
  output logic [3:0] dig_en,
  output logic       colon_out,
  output logic [1:0] slot_idx
);

  localparam int CNT_W = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int MAX_T = (BLANK_TICKS > DRIVE_TICKS) ? BLANK_TICKS : DRIVE_TICKS;
  localparam int PH_W  = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PRESC - 1);
  localparam logic [PH_W-1:0]  BLANK_LAST = PH_W'(BLANK_TICKS - 1);
  localparam logic [PH_W-1:0]  DRIVE_LAST = PH_W'(DRIVE_TICKS - 1);

  typedef enum logic {BLANK, DRIVE} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [PH_W-1:0]  phase_reg, phase_next;
  logic [1:0]       slot_reg, slot_next;
  logic [3:0]       dec_val_reg, dec_val_next;
  logic             dec_tens_reg, dec_tens_next;
  logic [3:0]       dig_en_reg, dig_en_next;
  logic             colon_reg, colon_next;

  logic             tick;
  logic [3:0]       d_sel;
  logic             invalid;
  logic             lz_blank;
  logic [3:0]       slot_onehot;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_onehot
      assign slot_onehot[gi] = (slot_reg == 2'(gi));
    end
  endgenerate

  always_comb begin
    d_sel = d0;
    case (slot_reg)
      2'd0: d_sel = d0;
      2'd1: d_sel = d1;
      2'd2: d_sel = d2;
      2'd3: d_sel = d3;
      default: d_sel = d0;
    endcase
  end

  // The minutes-tens digit only has a 0..5 decoder path, so 6..9 is also illegal there.
  assign invalid  = (d_sel > 4'd9) || ((slot_reg == 2'd1) && (d_sel > 4'd5));
  assign lz_blank = lzb_en && (slot_reg == 2'd3) && (d_sel == 4'd0);
  assign tick     = (cnt_reg == CNT_LAST) && !rst;

  always_comb begin
    state_next    = state_reg;
    phase_next    = phase_reg;
    slot_next     = slot_reg;
    dec_val_next  = dec_val_reg;
    dec_tens_next = dec_tens_reg;
    dig_en_next   = dig_en_reg;
    cnt_next      = tick ? '0 : cnt_reg + CNT_W'(1);

    case (state_reg)
      BLANK: begin
        if (tick) begin
          if (phase_reg == BLANK_LAST) begin
            state_next    = DRIVE;
            phase_next    = '0;
            dec_val_next  = invalid ? 4'hF : d_sel;
            dec_tens_next = slot_reg[0];
            dig_en_next   = (invalid || lz_blank) ? 4'b0000 : slot_onehot;
          end else begin
            phase_next = phase_reg + PH_W'(1);
          end
        end
      end
      DRIVE: begin
        if (tick) begin
          if (phase_reg == DRIVE_LAST) begin
            state_next  = BLANK;
            phase_next  = '0;
            slot_next   = slot_reg + 2'd1;
            dig_en_next = 4'b0000;
          end else begin
            phase_next = phase_reg + PH_W'(1);
          end
        end
      end
      default: state_next = BLANK;
    endcase

    // Registered form of colon_in AND (DRIVE) AND (slot 2), evaluated on the post-edge state.
    colon_next = colon_in && (state_next == DRIVE) && (slot_next == 2'd2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= BLANK;
      cnt_reg      <= '0;
      phase_reg    <= '0;
      slot_reg     <= 2'd0;
      dec_val_reg  <= 4'd0;
      dec_tens_reg <= 1'b0;
      dig_en_reg   <= 4'b0000;
      colon_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      phase_reg    <= phase_next;
      slot_reg     <= slot_next;
      dec_val_reg  <= dec_val_next;
      dec_tens_reg <= dec_tens_next;
      dig_en_reg   <= dig_en_next;
      colon_reg    <= colon_next;
    end
  end

  assign dec_val   = dec_val_reg;
  assign dec_tens  = dec_tens_reg;
  assign dig_en    = dig_en_reg;
  assign colon_out = colon_reg;
  assign slot_idx  = slot_reg;

endmodule

// File: doc/disp_scan_ctrl.md
# disp_scan_ctrl

Time-multiplexed scan controller for the 4-digit HH:MM LED display. It steps one shared BCD-to-7-segment decoder across all four digits (minutes units, minutes tens, hours units, hours tens) and drives the digit enables. Each digit slot has a dead-time blank phase to suppress ghosting. The block sits between the timekeeping counters and the external decoder/segment drivers, and it owns all timing of the display bus.

## Interface
- PRESC, 250, clocks per scan tick (≥1)
- BLANK_TICKS, 1, ticks of dead time per digit slot (≥1)
- DRIVE_TICKS, 4, ticks a digit is lit per slot (≥1)
- clk  in  1  system clock; the only clock
- rst  in  1  reset; synchronous, active-high
- d0  in  4  minutes units, BCD
- d1  in  4  minutes tens, BCD (legal 0–5)
- d2  in  4  hours units, BCD
- d3  in  4  hours tens, BCD (legal 0–2)
- lzb_en  in  1  1 = blank d3 when it is 0 (leading-zero blanking)
- colon_in  in  1  colon request (1 Hz blink source)
- dec_val  out  4  value presented to the shared decoder
- dec_tens  out  1  1 = current digit is a tens digit; selects the 0–5 decoder path for d1
- dig_en  out  4  one-hot digit enable, bit i = digit i lit; active-high
- colon_out  out  1  colon LED drive
- slot_idx  out  2  index of the current digit slot (debug/test)

## Operation
- Prescaler `cnt` counts 0..PRESC-1 and wraps. `tick` = (cnt == PRESC-1). `tick` is internal and does not assert during rst.
- FSM states:
  - BLANK: dig_en = 0. A phase counter counts ticks. On the BLANK_TICKS-th tick, go to DRIVE.
  - DRIVE: enable digit slot_idx. On the DRIVE_TICKS-th tick, go to BLANK and set slot_idx ← slot_idx+1 (3 wraps to 0).
- On the BLANK→DRIVE edge, latch d[slot_idx] into dec_val. It holds for the whole DRIVE phase, so input changes mid-phase are not visible until the next slot.
- dec_tens = 1 for slots 1 and 3, else 0. It is registered with dec_val.
- Invalid value (d > 9, or d1 > 5): latch dec_val = 4'hF and keep dig_en = 0 for that slot. Slot timing is unchanged.
- Leading-zero: if lzb_en = 1, slot 3, and d3 = 0, keep dig_en = 0 for that DRIVE phase. dec_val is still latched as 0.
- colon_out = colon_in AND (state == DRIVE) AND (slot_idx == 2). The colon is lit with the hours-units digit, so it shares that digit's duty cycle.
- At most one dig_en bit is ever set. dig_en is never set in BLANK.

## Timing
- All outputs are registered and change only on clk rising edges.
- Reset, taking effect on the first clk edge with rst = 1:
  - cnt = 0, phase = 0, state = BLANK, slot_idx = 0
  - dec_val = 0, dec_tens = 0, dig_en = 0, colon_out = 0
- rst asserted mid-slot forces the reset state on the next edge, regardless of phase. No digit remains enabled.
- Durations:
  - BLANK phase = BLANK_TICKS·PRESC clocks
  - DRIVE phase = DRIVE_TICKS·PRESC clocks
  - slot = (BLANK_TICKS+DRIVE_TICKS)·PRESC clocks
  - frame = 4 × slot
- After rst falls, the first DRIVE (slot 0) begins BLANK_TICKS·PRESC clocks later. dig_en and dec_val update on the same edge.
- Between consecutive lit digits there are always ≥ BLANK_TICKS·PRESC clocks with dig_en = 0.
- The slot_idx increment and the DRIVE→BLANK transition occur on the same edge.
- Counter widths must hold PRESC-1 and max(BLANK_TICKS, DRIVE_TICKS)-1 without overflow.

## Test plan
Parameters for all scenarios: PRESC=2, BLANK_TICKS=1, DRIVE_TICKS=2 (slot = 6 clk, frame = 24 clk).
- Reset/first slot: hold rst 3 clk, d0..d3 = 4,3,2,1 -> all outputs 0 while in reset; dig_en = 4'b0001 and dec_val = 4 exactly 2 clk after rst falls, held 4 clk, then dig_en = 0 for 2 clk.
- Full frame: same inputs, run 48 clk -> dig_en sequence 0001,0010,0100,1000 repeating every 24 clk; dec_val 4,3,2,1; dec_tens 0,1,0,1.
- Mid-phase change: change d0 from 4 to 7 one clk into slot-0 DRIVE -> dec_val stays 4 for that slot and shows 7 in the next frame's slot 0.
- Leading-zero and invalid values:
  - d3 = 0, lzb_en = 1 -> slot 3 dig_en = 0, timing preserved.
  - d3 = 0, lzb_en = 0 -> dig_en = 1000.
  - d1 = 6 -> slot 1 dec_val = F, dig_en = 0.
- Colon: colon_in = 1 -> colon_out high only during slot-2 DRIVE (4 clk per frame); colon_in = 0 -> colon_out never high.
- Reset mid-drive: assert rst during slot-2 DRIVE -> next edge dig_en = 0, slot_idx = 0, colon_out = 0; after release, slot 0 is lit 2 clk later.
